// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared state encoding and parameter defaults for microwave_ctrl
//
// Purpose : controller state codes (also shown on the display), default
//           timing parameters and the keypad digit filter.
// Ports   : none (package).

package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COOK   = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Clock cycles per 1 s tick and seconds of buzzer at the end of cooking.
  localparam int TICK_DIV_DEFAULT = 50_000_000;
  localparam int BEEP_S_DEFAULT   = 3;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // Keypad codes above 9 are not BCD digits and never reach the timer.
  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/microwave_ctrl_if.sv
// rtl/microwave_ctrl_if.sv - front panel, door and timer signals of microwave_ctrl
//
// Purpose : bundles everything the controller exchanges with its surroundings.
// Ports   : master drives the panel/door/timer-status side (key_valid,
//           key_digit, startn, stopn, door_closed, timer_zero) and observes
//           the controller outputs; slave is the controller (timer_data,
//           timer_loadn, timer_clr, timer_en, mag_on, beep, state_o).

interface microwave_ctrl_if;
  import microwave_pkg::*;

  logic       key_valid;
  logic [3:0] key_digit;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       timer_zero;

  logic [3:0] timer_data;
  logic       timer_loadn;
  logic       timer_clr;
  logic       timer_en;
  logic       mag_on;
  logic       beep;
  state_t     state_o;

  modport master (
    output key_valid, key_digit, startn, stopn, door_closed, timer_zero,
    input  timer_data, timer_loadn, timer_clr, timer_en, mag_on, beep, state_o
  );

  modport slave (
    input  key_valid, key_digit, startn, stopn, door_closed, timer_zero,
    output timer_data, timer_loadn, timer_clr, timer_en, mag_on, beep, state_o
  );

endinterface

// File: rtl/microwave_ctrl_tick_gen.sv
// rtl/microwave_ctrl_tick_gen.sv - one-second prescaler for the cooking countdown
//
// Purpose : counts 0..TICK_DIV-1 while run is high and flags the last count.
//           The count is held at 0 whenever run is low, so every new run
//           period starts a full second from zero.
// Ports   : clock  - system clock
//           clearn - synchronous active-low reset
//           run    - count enable (controller is cooking)
//           tick   - high for the one cycle the count sits at TICK_DIV-1

module tick_gen
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic clearn,
  input  logic run,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!clearn || !run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/microwave_ctrl.sv
// rtl/microwave_ctrl.sv - microwave oven sequencing controller
//
// Purpose : keypad entry into an external BCD minute/second timer, start/stop/
//           door handling, magnetron enable while cooking, one count-down
//           pulse per second, buzzer at the end.
// Ports   : clock  - system clock, all state changes on the rising edge
//           clearn - synchronous active-low reset
//           bus    - microwave_ctrl_if.slave: key_valid/key_digit keypad,
//                    startn/stopn buttons (active-low, debounced),
//                    door_closed, timer_zero in; timer_data/timer_loadn/
//                    timer_clr/timer_en timer control, mag_on, beep and
//                    state_o display code out.

module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int BEEP_S   = BEEP_S_DEFAULT
) (
  input  logic              clock,
  input  logic              clearn,
  microwave_ctrl_if.slave   bus
);

  // The buzzer runs for whole seconds, counted directly in clock cycles.
  localparam int            BEEP_CYC  = BEEP_S * TICK_DIV;
  localparam int            BW        = $clog2(BEEP_CYC);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYC - 1);

  state_t        state;
  state_t        state_n;

  logic          start_q;
  logic          stop_q;
  logic          start_ev;
  logic          stop_ev;
  logic          key_ok;
  logic          cooking;
  logic          tick;
  logic [BW-1:0] beep_cnt;

  logic          loadn_d;
  logic          clr_d;
  logic [3:0]    data_d;
  logic          loadn_q;
  logic          clr_q;
  logic [3:0]    data_q;

  // Button presses are the 1 -> 0 transitions of the active-low levels.
  always_ff @(posedge clock) begin
    if (!clearn) begin
      start_q <= 1'b1;
      stop_q  <= 1'b1;
    end else begin
      start_q <= bus.startn;
      stop_q  <= bus.stopn;
    end
  end

  assign start_ev = start_q & ~bus.startn;
  assign stop_ev  = stop_q & ~bus.stopn;
  assign key_ok   = bus.key_valid & is_bcd(bus.key_digit);
  assign cooking  = (state == COOK);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock  (clock),
    .clearn (clearn),
    .run    (cooking),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (!clearn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock) begin
    if (!clearn || state != DONE) begin
      beep_cnt <= '0;
    end else if (beep_cnt != BEEP_LAST) begin
      beep_cnt <= beep_cnt + BW'(1);
    end
  end

  // Next state plus the registered timer strobes. Stop is tested before
  // start everywhere so a simultaneous press always cancels.
  always_comb begin
    state_n = state;
    loadn_d = 1'b1;
    clr_d   = 1'b0;
    data_d  = '0;
    case (state)
      IDLE: begin
        if (key_ok) begin
          loadn_d = 1'b0;
          data_d  = bus.key_digit;
        end
        if (stop_ev) begin
          clr_d = 1'b1;
        end else if (start_ev && bus.door_closed && !bus.timer_zero) begin
          state_n = COOK;
        end
      end
      COOK: begin
        // Reaching 0:00 ends cooking even if the door opens on the same cycle.
        if (bus.timer_zero) begin
          state_n = DONE;
        end else if (stop_ev || !bus.door_closed) begin
          state_n = PAUSED;
        end
      end
      PAUSED: begin
        if (stop_ev) begin
          clr_d   = 1'b1;
          state_n = IDLE;
        end else if (start_ev && bus.door_closed) begin
          state_n = COOK;
        end
      end
      DONE: begin
        // Any key press silences the buzzer but is not loaded.
        if (stop_ev || !bus.door_closed || bus.key_valid || beep_cnt == BEEP_LAST) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Timer clear is held high through reset so the display reads 0:00.
  always_ff @(posedge clock) begin
    if (!clearn) begin
      loadn_q <= 1'b1;
      clr_q   <= 1'b1;
      data_q  <= '0;
    end else begin
      loadn_q <= loadn_d;
      clr_q   <= clr_d;
      data_q  <= data_d;
    end
  end

  assign bus.timer_loadn = loadn_q;
  assign bus.timer_data  = data_q;
  assign bus.timer_clr   = clr_q;
  assign bus.timer_en    = tick & cooking & ~bus.timer_zero;
  assign bus.mag_on      = cooking;
  assign bus.beep        = (state == DONE);
  assign bus.state_o     = state;

endmodule

// File: doc/microwave_ctrl.md
MICROWAVE_CTRL -- requirements
Module: microwave_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clock cycles per 1 s tick (min 2).
REQ-002 SHALL have parameter BEEP_S, default 3, seconds the buzzer sounds in DONE (min 1).
REQ-003 clock  in  1  single system clock, all state updates on rising edge.
REQ-004 clearn  in  1  reset, synchronous, active-low.
REQ-005 key_valid  in  1  one-cycle strobe, keypad digit present.
REQ-006 key_digit  in  4  BCD digit 0-9 (values >9 ignored, no load).
REQ-007 startn  in  1  start button, active-low level, already debounced.
REQ-008 stopn  in  1  stop/cancel button, active-low level, already debounced.
REQ-009 door_closed  in  1  1 = door closed.
REQ-010 timer_zero  in  1  timer reads 0:00.
REQ-011 timer_data  out  4  digit presented to timer load input.
REQ-012 timer_loadn  out  1  timer synchronous load strobe, active-low.
REQ-013 timer_clr  out  1  timer clear, active-high.
REQ-014 timer_en  out  1  timer count-down enable, one-cycle pulse per second.
REQ-015 mag_on  out  1  magnetron/lamp enable.
REQ-016 beep  out  1  buzzer.
REQ-017 state_o  out  2  current state code for display.

Function
REQ-018 States SHALL be IDLE=0, COOK=1, PAUSED=2, DONE=3.
REQ-019 start_ev/stop_ev SHALL be falling-edge detections of startn/stopn (1-cycle, registered previous value).
REQ-020 IDLE: valid key_valid SHALL drive timer_loadn=0 and timer_data=key_digit for exactly one cycle (registered, 1-cycle latency), shifting the digit into seconds-ones; older digits shift up, the minutes digit is discarded.
REQ-021 IDLE: stop_ev SHALL pulse timer_clr for one cycle.
REQ-022 IDLE: start_ev with door_closed=1 and timer_zero=0 SHALL go to COOK; otherwise stay IDLE.
REQ-023 COOK: mag_on=1; prescaler counts 0..TICK_DIV-1, tick on count TICK_DIV-1; timer_en = tick AND NOT timer_zero.
REQ-024 Prescaler SHALL reset to 0 on every entry into COOK.
REQ-025 COOK: timer_zero=1 SHALL go to DONE next cycle, with priority over door and stop.
REQ-026 COOK: stop_ev or door_closed=0 SHALL go to PAUSED; timer value retained.
REQ-027 PAUSED: start_ev with door_closed=1 SHALL go to COOK; stop_ev SHALL pulse timer_clr and go to IDLE.
REQ-028 DONE: beep=1 for BEEP_S ticks, then IDLE; stop_ev, door_closed=0 or key_valid SHALL end DONE early (to IDLE).
REQ-029 start_ev and stop_ev in the same cycle: stop SHALL win.
REQ-030 key_valid outside IDLE SHALL be ignored (except REQ-028); timer_loadn SHALL be 1 outside IDLE.
REQ-031 mag_on SHALL be 1 only in COOK; timer_en SHALL never pulse outside COOK.

Reset
REQ-032 clearn=0 at a clock edge SHALL force IDLE, prescaler/beep counters 0, edge registers 1, and outputs timer_loadn=1, timer_clr=1 (clear timer while in reset), timer_en=0, mag_on=0, beep=0, timer_data=0, state_o=0.
REQ-033 Reset mid-COOK SHALL drop mag_on on the same edge.

Structure
REQ-034 State encoding and TICK_DIV/BEEP_S defaults SHALL live in shared package microwave_pkg.
REQ-035 Prescaler SHALL be a sub-module tick_gen (clock, clearn, run, tick).

Verification (TICK_DIV=4, BEEP_S=2)
REQ-036 Keys 1,3,0 in IDLE -> three single-cycle timer_loadn pulses, timer_data 1,3,0; timer shows 1:30.
REQ-037 Time 0:03, door closed, start -> COOK, timer_en every 4 cycles, 3 pulses, DONE the cycle after zero, beep 8 cycles, then IDLE.
REQ-038 Door opens mid-COOK -> PAUSED next cycle, mag_on=0, no timer_en; close + start -> COOK, prescaler restarts at 0.
REQ-039 Start with door open or timer 0:00 -> stays IDLE, mag_on=0; start+stop same cycle in PAUSED -> IDLE, timer_clr pulse.
REQ-040 clearn=0 for one edge mid-COOK -> IDLE, mag_on=0, timer_clr=1 during reset, all outputs at reset values.
